// File: rtl/pps_pulse_monitor.sv
// Measures a divided-PPS pulse train against raw PPS: phase (us after PPS rise), width (us)
// and divide number (PPS rises between consecutive pulse rises).
module pps_pulse_monitor #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CLKS_PER_US = 10
) (
    input  logic                      i_clk_10,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic                      i_pps_raw,
    input  logic                      i_pulse,
    output logic [DATA_WIDTH*4-1:0]   o_phase_us,
    output logic [DATA_WIDTH-1:0]     o_width_us,
    output logic [DATA_WIDTH-1:0]     o_div_number,
    output logic                      o_div_valid,
    output logic                      o_valid,
    output logic                      o_sat
);

    localparam int unsigned PW    = DATA_WIDTH * 4;
    localparam int unsigned PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_US - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_PPS  = 2'd1;
    localparam logic [1:0] ST_WAIT_RISE = 2'd2;
    localparam logic [1:0] ST_HIGH      = 2'd3;

    logic [2:0] pps_sync_q;
    logic [2:0] pulse_sync_q;
    logic       pps_rise;
    logic       pulse_rise;
    logic       pulse_fall;

    // Identical synchronisers keep the relative timing of both inputs exact.
    always_ff @(posedge i_clk_10) begin
        pps_sync_q   <= {pps_sync_q[1:0], i_pps_raw};
        pulse_sync_q <= {pulse_sync_q[1:0], i_pulse};
    end

    assign pps_rise   = pps_sync_q[1] & ~pps_sync_q[2];
    assign pulse_rise = pulse_sync_q[1] & ~pulse_sync_q[2];
    assign pulse_fall = ~pulse_sync_q[1] & pulse_sync_q[2];

    // Phase timebase, restarted by every PPS rise.
    logic [PRE_W-1:0] ph_pre_q, ph_pre_d;
    logic [PW-1:0]    ph_us_q, ph_us_d;
    logic             ph_sat_hit;

    always_comb begin
        ph_pre_d   = ph_pre_q;
        ph_us_d    = ph_us_q;
        ph_sat_hit = 1'b0;
        if (pps_rise) begin
            ph_pre_d = '0;
            ph_us_d  = '0;
        end else if (ph_pre_q == PRE_MAX) begin
            ph_pre_d = '0;
            if (ph_us_q == '1) begin
                ph_sat_hit = 1'b1;
            end else begin
                ph_us_d = ph_us_q + PW'(1);
            end
        end else begin
            ph_pre_d = ph_pre_q + PRE_W'(1);
        end
    end

    // Width timebase, restarted by every pulse rise.
    logic [PRE_W-1:0]      wd_pre_q, wd_pre_d;
    logic [DATA_WIDTH-1:0] wd_us_q, wd_us_d;
    logic                  wd_sat_hit;

    always_comb begin
        wd_pre_d   = wd_pre_q;
        wd_us_d    = wd_us_q;
        wd_sat_hit = 1'b0;
        if (pulse_rise) begin
            wd_pre_d = '0;
            wd_us_d  = '0;
        end else if (wd_pre_q == PRE_MAX) begin
            wd_pre_d = '0;
            if (wd_us_q == '1) begin
                wd_sat_hit = 1'b1;
            end else begin
                wd_us_d = wd_us_q + DATA_WIDTH'(1);
            end
        end else begin
            wd_pre_d = wd_pre_q + PRE_W'(1);
        end
    end

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] pps_cnt_q, pps_cnt_d, pps_cnt_inc;
    logic                  pps_sat_hit;
    logic                  have_rise_q, have_rise_d;
    logic [PW-1:0]         phase_cap_q, phase_cap_d;
    logic [PW-1:0]         phase_d;
    logic [DATA_WIDTH-1:0] width_d;
    logic [DATA_WIDTH-1:0] div_d;
    logic                  div_valid_d;
    logic                  valid_d;
    logic                  sat_d;

    // PPS count including a rise landing in the current cycle, saturating.
    always_comb begin
        pps_cnt_inc = pps_cnt_q;
        pps_sat_hit = 1'b0;
        if (pps_rise) begin
            if (pps_cnt_q == '1) begin
                pps_sat_hit = 1'b1;
            end else begin
                pps_cnt_inc = pps_cnt_q + DATA_WIDTH'(1);
            end
        end
    end

    // The *_d timebase values are used at capture so the current cycle is counted.
    always_comb begin
        state_d     = state_q;
        pps_cnt_d   = pps_cnt_inc;
        have_rise_d = have_rise_q;
        phase_cap_d = phase_cap_q;
        phase_d     = o_phase_us;
        width_d     = o_width_us;
        div_d       = o_div_number;
        div_valid_d = o_div_valid;
        valid_d     = 1'b0;
        sat_d       = o_sat;

        if (!i_enable) begin
            state_d     = ST_IDLE;
            have_rise_d = 1'b0;
            div_valid_d = 1'b0;
            sat_d       = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_PPS;
                end
                ST_WAIT_PPS: begin
                    if (pps_rise) begin
                        pps_cnt_d = '0;
                        if (pulse_rise) begin
                            state_d     = ST_HIGH;
                            phase_cap_d = '0;
                            have_rise_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_RISE;
                        end
                    end
                end
                ST_WAIT_RISE: begin
                    if (pulse_rise) begin
                        state_d     = ST_HIGH;
                        phase_cap_d = ph_us_d;
                        if (have_rise_q) begin
                            div_d       = pps_cnt_inc;
                            div_valid_d = 1'b1;
                        end
                        have_rise_d = 1'b1;
                        pps_cnt_d   = '0;
                    end
                end
                ST_HIGH: begin
                    if (pulse_fall) begin
                        state_d = ST_WAIT_RISE;
                        phase_d = phase_cap_q;
                        width_d = wd_us_d;
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if ((ph_sat_hit && state_q == ST_WAIT_RISE) ||
                (wd_sat_hit && state_q == ST_HIGH) ||
                (pps_sat_hit && state_q != ST_IDLE)) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_10) begin
        if (i_rst) begin
            ph_pre_q     <= '0;
            ph_us_q      <= '0;
            wd_pre_q     <= '0;
            wd_us_q      <= '0;
            state_q      <= ST_IDLE;
            pps_cnt_q    <= '0;
            have_rise_q  <= 1'b0;
            phase_cap_q  <= '0;
            o_phase_us   <= '0;
            o_width_us   <= '0;
            o_div_number <= '0;
            o_div_valid  <= 1'b0;
            o_valid      <= 1'b0;
            o_sat        <= 1'b0;
        end else begin
            ph_pre_q     <= ph_pre_d;
            ph_us_q      <= ph_us_d;
            wd_pre_q     <= wd_pre_d;
            wd_us_q      <= wd_us_d;
            state_q      <= state_d;
            pps_cnt_q    <= pps_cnt_d;
            have_rise_q  <= have_rise_d;
            phase_cap_q  <= phase_cap_d;
            o_phase_us   <= phase_d;
            o_width_us   <= width_d;
            o_div_number <= div_d;
            o_div_valid  <= div_valid_d;
            o_valid      <= valid_d;
            o_sat        <= sat_d;
        end
    end

endmodule

// File: tb/tb_pps_pulse_monitor.sv
// Directed bench for pps_pulse_monitor: PPS period shortened to 2000 clocks, 10 clocks per us.
module tb_pps_pulse_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        pps;
    logic        pulse;
    logic [31:0] o_phase_us;
    logic [7:0]  o_width_us;
    logic [7:0]  o_div_number;
    logic        o_div_valid;
    logic        o_valid;
    logic        o_sat;

    pps_pulse_monitor #(
        .DATA_WIDTH (8),
        .CLKS_PER_US(10)
    ) dut (
        .i_clk_10    (clk),
        .i_rst       (rst),
        .i_enable    (en),
        .i_pps_raw   (pps),
        .i_pulse     (pulse),
        .o_phase_us  (o_phase_us),
        .o_width_us  (o_width_us),
        .o_div_number(o_div_number),
        .o_div_valid (o_div_valid),
        .o_valid     (o_valid),
        .o_sat       (o_sat)
    );

    always #50 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nvalid;
    int cyc;
    bit pat_on;
    int k_div;
    int off;
    int wid;
    int exp_phase;
    int exp_width;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pattern: PPS high 200 clks every 2000; pulse every k_div PPS, off clks late, wid wide.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (pat_on) begin
                int m;
                pps   = (cyc % 2000) < 200;
                m     = cyc % (k_div * 2000);
                pulse = (m >= off) && (m < off + wid);
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (o_valid) begin
                nvalid++;
                check("phase_at_valid", o_phase_us, 32'(exp_phase));
                check("width_at_valid", 32'(o_width_us), 32'(exp_width));
            end
        end
    endtask

    task automatic start(input int k, input int o, input int w, input int ep, input int ew);
        en     = 1'b0;
        pat_on = 1'b0;
        pps    = 1'b0;
        pulse  = 1'b0;
        run(4);
        check("div_valid_cleared_by_disable", 32'(o_div_valid), 32'd0);
        check("sat_cleared_by_disable", 32'(o_sat), 32'd0);
        en = 1'b1;
        run(4);
        k_div     = k;
        off       = o;
        wid       = w;
        exp_phase = ep;
        exp_width = ew;
        cyc       = 0;
        nvalid    = 0;
        pat_on    = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pps = 1'b0; pulse = 1'b0;
        pat_on = 1'b0; cyc = 0; nvalid = 0;
        k_div = 1; off = 0; wid = 1; exp_phase = 0; exp_width = 0;
        @(negedge clk);
        run(3);
        rst = 1'b0;
        run(1);
        check("rst_phase", o_phase_us, 32'd0);
        check("rst_width", 32'(o_width_us), 32'd0);
        check("rst_div", 32'(o_div_number), 32'd0);
        check("rst_div_valid", 32'(o_div_valid), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_sat", 32'(o_sat), 32'd0);

        // 1: one pulse per PPS, 50 clks late, 30 wide
        start(1, 50, 30, 5, 3);
        run(10000);
        check("t1_nvalid", 32'(nvalid), 32'd5);
        check("t1_div", 32'(o_div_number), 32'd1);
        check("t1_div_valid", 32'(o_div_valid), 32'd1);
        en = 1'b0;
        run(4);
        check("t1_phase_hold", o_phase_us, 32'd5);
        check("t1_width_hold", 32'(o_width_us), 32'd3);

        // 2: every 3rd PPS, 120 clks late, 70 wide
        start(3, 120, 70, 12, 7);
        run(18000);
        check("t2_nvalid", 32'(nvalid), 32'd3);
        check("t2_div", 32'(o_div_number), 32'd3);
        check("t2_div_valid", 32'(o_div_valid), 32'd1);

        // 3: pulse rise coincides with PPS rise, every 2nd PPS
        start(2, 0, 30, 0, 3);
        run(12000);
        check("t3_nvalid", 32'(nvalid), 32'd3);
        check("t3_div", 32'(o_div_number), 32'd2);
        check("t3_div_valid", 32'(o_div_valid), 32'd1);

        // 4: 300 us wide pulse saturates the width counter
        start(2, 50, 3000, 5, 255);
        run(4000);
        check("t4_nvalid", 32'(nvalid), 32'd1);
        check("t4_sat", 32'(o_sat), 32'd1);
        check("t4_div_valid_first_rise", 32'(o_div_valid), 32'd0);
        en = 1'b0;
        run(4);
        check("t4_sat_cleared", 32'(o_sat), 32'd0);
        check("t4_width_hold", 32'(o_width_us), 32'd255);

        // 5: reset while the pulse is high
        start(1, 50, 30, 5, 3);
        run(2065);
        check("t5_nvalid_before_rst", 32'(nvalid), 32'd1);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        check("t5_rst_phase", o_phase_us, 32'd0);
        check("t5_rst_width", 32'(o_width_us), 32'd0);
        check("t5_rst_div", 32'(o_div_number), 32'd0);
        check("t5_rst_div_valid", 32'(o_div_valid), 32'd0);
        check("t5_rst_valid", 32'(o_valid), 32'd0);
        check("t5_rst_sat", 32'(o_sat), 32'd0);
        nvalid = 0;
        run(200);
        check("t5_no_valid_after_rst", 32'(nvalid), 32'd0);

        // 6: pulse high at arm, pulse before first PPS, pulse held across PPS
        en = 1'b0; pat_on = 1'b0; pps = 1'b0; pulse = 1'b1;
        run(4);
        en = 1'b1;
        run(10);
        nvalid = 0;
        exp_phase = 5;
        exp_width = 3;
        pulse = 1'b0; run(20);
        pulse = 1'b1; run(20);
        pulse = 1'b0; run(20);
        pulse = 1'b1; run(20);
        pps = 1'b1;   run(20);
        pps = 1'b0;   run(20);
        pulse = 1'b0; run(20);
        check("t6_no_false_valid", 32'(nvalid), 32'd0);
        check("t6_no_div_yet", 32'(o_div_valid), 32'd0);
        k_div = 1; off = 50; wid = 30; cyc = 0; pat_on = 1'b1;
        run(1000);
        check("t6_first_valid", 32'(nvalid), 32'd1);
        check("t6_no_div_after_first_rise", 32'(o_div_valid), 32'd0);
        run(3200);
        check("t6_nvalid", 32'(nvalid), 32'd3);
        check("t6_div", 32'(o_div_number), 32'd1);
        check("t6_div_valid", 32'(o_div_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
